run_seq_ctrl: RTL

RUN_SEQ_CTRL -- requirements
Module: run_seq_ctrl

---
 rtl/run_pkg.sv | 21 ++
 rtl/run_len_det.sv | 37 +++
 rtl/run_seq_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/run_pkg.sv
// Shared definitions for the run-sequence controller: FSM encoding and the
// saturating run-counter used by the detector.
package run_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FLUSH  = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int               RUN_W   = 3;
  localparam logic [RUN_W-1:0] RUN_SAT = 3'd5;  // 5 stands for "longer than 4"

  function automatic logic [RUN_W-1:0] run_next(input logic [RUN_W-1:0] run,
                                                input logic             bit_val);
    if (!bit_val) return '0;
    return (run == RUN_SAT) ? RUN_SAT : run + 1'b1;
  endfunction

endpackage

// File: rtl/run_len_det.sv
// Run-length detector: tracks consecutive 1s and flags a hit, one cycle late,
// when a 0 ends a run of exactly RUN_A or RUN_B.
module run_len_det
  import run_pkg::*;
#(
  parameter int RUN_A = 2,
  parameter int RUN_B = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic bit_en,
  input  logic clr,
  output logic hit
);

  localparam logic [RUN_W-1:0] LEN_A = RUN_W'(RUN_A);
  localparam logic [RUN_W-1:0] LEN_B = RUN_W'(RUN_B);

  logic [RUN_W-1:0] run_q;
  logic             hit_d;

  assign hit_d = bit_en && !bit_in && ((run_q == LEN_A) || (run_q == LEN_B));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset here is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      run_q <= '0;
      hit   <= 1'b0;
    end else begin
      hit <= hit_d;
      if (bit_en) run_q <= run_next(run_q, bit_in);
    end
  end

endmodule

// File: rtl/run_seq_ctrl.sv
// Frame-level controller: accepts words, serialises them LSB first into the
// run detector, flushes a trailing run and reports the saturated hit count.
module run_seq_ctrl
  import run_pkg::*;
#(
  parameter int W     = 8,
  parameter int RUN_A = 2,
  parameter int RUN_B = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [7:0]   out_count,
  input  logic         out_ready,
  output logic         busy
);

  localparam int            IW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  data_q;
  logic          last_q;
  logic [IW-1:0] bit_idx_q;
  logic [7:0]    count_q;
  logic          out_valid_q;
  logic          accept, hs_out, hit, det_bit, det_en;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_count = count_q;
  assign accept    = in_valid && in_ready;
  assign hs_out    = out_valid_q && out_ready;

  // FLUSH feeds a forced 0 so a run ending at the last bit still terminates.
  assign det_en  = (state_q == SHIFT) || (state_q == FLUSH);
  assign det_bit = (state_q == SHIFT) ? data_q[bit_idx_q] : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (bit_idx_q == LAST_IDX) state_d = last_q ? FLUSH : IDLE;
      FLUSH:   state_d = REPORT;
      REPORT:  if (hs_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // out_valid rises one cycle into REPORT, once the flush hit has been counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q      <= '0;
      last_q      <= 1'b0;
      bit_idx_q   <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        data_q <= in_data;
        last_q <= in_last;
      end
      if (state_q == SHIFT)
        bit_idx_q <= (bit_idx_q == LAST_IDX) ? '0 : bit_idx_q + 1'b1;
      if (hs_out) begin
        count_q     <= '0;
        out_valid_q <= 1'b0;
      end else begin
        if (hit && (count_q != 8'hFF)) count_q <= count_q + 8'd1;
        if (state_q == REPORT) out_valid_q <= 1'b1;
      end
    end
  end

  run_len_det #(
    .RUN_A(RUN_A),
    .RUN_B(RUN_B)
  ) u_det (
    .clk   (clk),
    .reset (reset),
    .bit_in(det_bit),
    .bit_en(det_en),
    .clr   (hs_out),
    .hit   (hit)
  );

endmodule
